conv_result_collector: RTL and testbench
========================================

// Module: conv_result_collector
// PURPOSE
//  Downstream stage of the convolution accelerator. Captures one result per completed convolution: one result per cReady rising edge, sampled from finalsum.
//  Adds a per-frame bias, saturates, optionally applies ReLU, and tags each result with row/col/last.
//  Buffers results in a small FIFO with a valid/ready output toward the DMA/writeback stage.
//  Tracks frame completion and flags dropped results.
// PARAMETERS
//  BIT_LENGTH  16  result width; matches `bitLength
//  OUT_W       4   output feature-map width (results per row)
//  OUT_H       4   output feature-map height (rows per frame)
//  FIFO_DEPTH  8   output FIFO entries (power of 2, >=2)
//  RELU_EN     1   1: clamp negative results to 0 after saturation
// PORTS
//  Clk          in   1           single clock, all logic on posedge
//  Rst          in   1           synchronous reset, active-low
//  frame_start  in   1           1-cycle pulse; arms a new frame, latches bias
//  bias         in   BIT_LENGTH  signed bias, sampled when frame_start accepted
//  cReady       in   1           accelerator result-ready level
//  finalsum     in   BIT_LENGTH  signed accelerator result, valid while cReady=1
//  out_ready    in   1           downstream accept
//  out_valid    out  1           out_data/out_last valid
//  out_data     out  BIT_LENGTH  processed signed result
//  out_last     out  1           entry is row OUT_H-1, col OUT_W-1
//  busy         out  1           state != IDLE
//  frame_done   out  1           1-cycle pulse on DRAIN->IDLE
//  overflow     out  1           sticky: a result was dropped (FIFO full)
// BEHAVIOUR
//  Reset (Rst=0 at posedge): state=IDLE, FIFO emptied, pipeline valids=0, row=col=0,
//   all outputs 0, bias_reg=0, cReady_d=1 (a cReady already high at reset release is NOT captured).
//  Capture: cap = cReady & ~cReady_d & (state==RUN); cReady_d <= cReady every cycle.
//   A cReady held high for N cycles produces exactly one capture.
//  FSM: IDLE --frame_start--> RUN (bias_reg<=bias, row/col/overflow cleared).
//   RUN --capture of result #OUT_W*OUT_H--> DRAIN.
//   DRAIN --both pipeline stages empty & FIFO empty--> IDLE, frame_done=1 for that cycle.
//   frame_start in RUN/DRAIN ignored; cReady edges in IDLE/DRAIN ignored.
//  Pipeline, fixed 2 stages, no stall (never blocks capture):
//   S1 (edge after cap): sum = sext(finalsum)+sext(bias_reg), BIT_LENGTH+1 bits;
//    tag last = (row==OUT_H-1 && col==OUT_W-1); col++, wrapping to 0 at OUT_W-1 with row++.
//   S2: saturate sum to [-2^(BIT_LENGTH-1), 2^(BIT_LENGTH-1)-1]; if RELU_EN and negative -> 0.
//    Push {last,data} into FIFO at end of S2.
//  Latency: cap sampled at edge k -> out_valid=1 after edge k+3 when FIFO was empty.
//  FIFO: first-word on outputs; pop when out_valid & out_ready.
//   Push & pop in the same cycle when full -> both happen, count unchanged.
//   Push when full without pop -> entry dropped, overflow<=1 (cleared only by reset or a new frame_start).
//   Row/col advance on every capture, including dropped ones, so tags stay aligned.
//  out_data/out_last are held stable while out_valid=1 & out_ready=0.
//  Reset mid-frame: all state is discarded and out_valid falls after that edge. No partial frame_done.
// TESTING (OUT_W=2, OUT_H=2, FIFO_DEPTH=4, BIT_LENGTH=16 unless noted)
//  1 RELU_EN=1, bias=5; finalsum 10,20,0xFFFD,7, out_ready=1 -> out_data 15,25,2,12;
//    out_last only on 12; frame_done pulse once; busy falls with it.
//  2 RELU_EN=0: bias=0x7FF0, sum 0x0100 -> 0x7FFF; bias=0x8000, sum 0xFFFF -> 0x8000;
//    RELU_EN=1, bias=0, sum 0xFF00 -> 0x0000.
//  3 OUT_W=3, OUT_H=2, out_ready=0, 6 captures -> 4 stored (first four), overflow=1;
//    raise out_ready -> 4 pops, none with out_last; frame_done after the FIFO empties.
//  4 cReady held high for 5 cycles -> exactly one result. cReady high during and after reset release -> 0 results until low->high.
//  5 Latency/handshake: single capture at edge k -> out_valid at k+3. Toggle out_ready every cycle -> data stable while stalled, no duplicates or losses.
//  6 Rst=0 after 2 captures -> next cycle out_valid=0, busy=0, overflow=0; a new frame_start restarts at row=col=0.

Source files
------------

// File: rtl/conv_result_collector.sv
// Result collector behind the convolution core: captures one result per cReady rising edge,
// adds the frame bias, saturates, optionally applies ReLU, tags row/col/last and buffers the results.
module conv_result_collector #(
  parameter int unsigned BIT_LENGTH = 16,
  parameter int unsigned OUT_W      = 4,
  parameter int unsigned OUT_H      = 4,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter bit          RELU_EN    = 1'b1
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic                  frame_start,
  input  logic [BIT_LENGTH-1:0] bias,
  input  logic                  cReady,
  input  logic [BIT_LENGTH-1:0] finalsum,
  input  logic                  out_ready,
  output logic                  out_valid,
  output logic [BIT_LENGTH-1:0] out_data,
  output logic                  out_last,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  overflow
);

  localparam int unsigned SUM_W = BIT_LENGTH + 1;
  localparam int unsigned ROW_W = (OUT_H > 1) ? $clog2(OUT_H) : 1;
  localparam int unsigned COL_W = (OUT_W > 1) ? $clog2(OUT_W) : 1;
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  localparam logic [BIT_LENGTH-1:0] SAT_MAX = {1'b0, {(BIT_LENGTH-1){1'b1}}};
  localparam logic [BIT_LENGTH-1:0] SAT_MIN = {1'b1, {(BIT_LENGTH-1){1'b0}}};

  typedef struct packed {
    logic                  last;
    logic [BIT_LENGTH-1:0] data;
  } entry_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t state, state_n;

  logic                  cready_d;
  logic [BIT_LENGTH-1:0] bias_reg;
  logic [ROW_W-1:0]      row;
  logic [COL_W-1:0]      col;

  logic                  s1_valid;
  logic                  s1_last;
  logic [SUM_W-1:0]      s1_sum;
  logic                  s2_valid;
  logic                  s2_last;
  logic [BIT_LENGTH-1:0] s2_data;

  entry_t                mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [CNT_W-1:0]      mem_cnt;

  logic                  cap_c;
  logic                  last_pos_c;
  logic [SUM_W-1:0]      sum_c;
  logic [BIT_LENGTH-1:0] sat_c;
  logic [CNT_W-1:0]      total_c;
  logic                  full_c;
  logic                  pop_c;
  logic                  push_c;
  logic                  drop_c;
  logic                  load_c;
  logic                  done_c;

  // Edge detect: a level held high yields a single capture, only while a frame is running
  assign cap_c      = cReady & ~cready_d & (state == RUN);
  assign last_pos_c = (row == ROW_W'(OUT_H - 1)) && (col == COL_W'(OUT_W - 1));
  assign sum_c      = {finalsum[BIT_LENGTH-1], finalsum} + {bias_reg[BIT_LENGTH-1], bias_reg};

  // Saturate the widened sum back to BIT_LENGTH, then optional ReLU
  always_comb begin
    sat_c = s1_sum[BIT_LENGTH-1:0];
    if (s1_sum[SUM_W-1] != s1_sum[SUM_W-2]) begin
      sat_c = s1_sum[SUM_W-1] ? SAT_MIN : SAT_MAX;
    end
    if (RELU_EN && sat_c[BIT_LENGTH-1]) begin
      sat_c = '0;
    end
  end

  // Occupancy counts the head register plus the entries still in memory
  assign total_c = mem_cnt + CNT_W'(out_valid);
  assign full_c  = (total_c == CNT_W'(FIFO_DEPTH));
  assign pop_c   = out_valid & out_ready;
  assign push_c  = s2_valid & (~full_c | pop_c);
  assign drop_c  = s2_valid & full_c & ~pop_c;
  assign load_c  = (mem_cnt != '0) & (~out_valid | pop_c);

  always_comb begin
    state_n = state;
    done_c  = 1'b0;
    case (state)
      IDLE: begin
        if (frame_start) state_n = RUN;
      end
      RUN: begin
        if (cap_c && last_pos_c) state_n = DRAIN;
      end
      DRAIN: begin
        if (!s1_valid && !s2_valid && (total_c == '0)) begin
          state_n = IDLE;
          done_c  = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      state      <= IDLE;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      cready_d   <= 1'b1;
    end else begin
      state      <= state_n;
      busy       <= (state_n != IDLE);
      frame_done <= done_c;
      cready_d   <= cReady;
    end
  end

  // Frame setup, position tracking and the two processing stages
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      bias_reg <= '0;
      row      <= '0;
      col      <= '0;
      overflow <= 1'b0;
      s1_valid <= 1'b0;
      s1_last  <= 1'b0;
      s1_sum   <= '0;
      s2_valid <= 1'b0;
      s2_last  <= 1'b0;
      s2_data  <= '0;
    end else begin
      if (state == IDLE && frame_start) begin
        bias_reg <= bias;
        row      <= '0;
        col      <= '0;
        overflow <= 1'b0;
      end
      s1_valid <= cap_c;
      if (cap_c) begin
        s1_sum  <= sum_c;
        s1_last <= last_pos_c;
        if (col == COL_W'(OUT_W - 1)) begin
          col <= '0;
          row <= (row == ROW_W'(OUT_H - 1)) ? '0 : row + ROW_W'(1);
        end else begin
          col <= col + COL_W'(1);
        end
      end
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_data <= sat_c;
        s2_last <= s1_last;
      end
      if (drop_c) overflow <= 1'b1;
    end
  end

  always_ff @(posedge Clk) begin
    if (push_c) mem[wr_ptr] <= '{last: s2_last, data: s2_data};
  end

  // FIFO pointers and the registered head entry presented downstream
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      mem_cnt   <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
    end else begin
      if (push_c) wr_ptr <= wr_ptr + PTR_W'(1);
      if (load_c) begin
        rd_ptr    <= rd_ptr + PTR_W'(1);
        out_data  <= mem[rd_ptr].data;
        out_last  <= mem[rd_ptr].last;
        out_valid <= 1'b1;
      end else if (pop_c) begin
        out_valid <= 1'b0;
      end
      mem_cnt <= mem_cnt + CNT_W'(push_c) - CNT_W'(load_c);
    end
  end

endmodule

// File: tb/tb_conv_result_collector.sv
// Directed bench for conv_result_collector: three instances (ReLU, no ReLU, 3x2 frame) on shared stimulus.
module tb_conv_result_collector;

  logic        Clk = 1'b0;
  logic        Rst;
  logic        fs_ab;
  logic        fs_c;
  logic [15:0] bias;
  logic        cReady;
  logic [15:0] finalsum;
  logic        out_ready;

  logic        a_valid, a_last, a_busy, a_fd, a_ovf;
  logic [15:0] a_data;
  logic        b_valid, b_last, b_busy, b_fd, b_ovf;
  logic [15:0] b_data;
  logic        c_valid, c_last, c_busy, c_fd, c_ovf;
  logic [15:0] c_data;

  int errors = 0;
  int checks = 0;

  logic [16:0] pa [256];
  logic [16:0] pb [256];
  logic [16:0] pc [256];
  int  na = 0, nb = 0, nc = 0;
  int  fd_a = 0, fd_c = 0;
  time last_pop_c = 0, fd_t_c = 0;
  bit  stab_en = 1'b0;
  bit  prev_stall = 1'b0;
  logic [17:0] prev_word = '0;

  always #5 Clk = ~Clk;

  conv_result_collector #(.BIT_LENGTH(16), .OUT_W(2), .OUT_H(2), .FIFO_DEPTH(4), .RELU_EN(1'b1)) dut_a (
    .Clk(Clk), .Rst(Rst), .frame_start(fs_ab), .bias(bias), .cReady(cReady), .finalsum(finalsum),
    .out_ready(out_ready), .out_valid(a_valid), .out_data(a_data), .out_last(a_last),
    .busy(a_busy), .frame_done(a_fd), .overflow(a_ovf));

  conv_result_collector #(.BIT_LENGTH(16), .OUT_W(2), .OUT_H(2), .FIFO_DEPTH(4), .RELU_EN(1'b0)) dut_b (
    .Clk(Clk), .Rst(Rst), .frame_start(fs_ab), .bias(bias), .cReady(cReady), .finalsum(finalsum),
    .out_ready(out_ready), .out_valid(b_valid), .out_data(b_data), .out_last(b_last),
    .busy(b_busy), .frame_done(b_fd), .overflow(b_ovf));

  conv_result_collector #(.BIT_LENGTH(16), .OUT_W(3), .OUT_H(2), .FIFO_DEPTH(4), .RELU_EN(1'b1)) dut_c (
    .Clk(Clk), .Rst(Rst), .frame_start(fs_c), .bias(bias), .cReady(cReady), .finalsum(finalsum),
    .out_ready(out_ready), .out_valid(c_valid), .out_data(c_data), .out_last(c_last),
    .busy(c_busy), .frame_done(c_fd), .overflow(c_ovf));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Record every accepted transfer and frame_done pulse, mid-cycle
  always @(negedge Clk) begin
    if (a_valid && out_ready && na < 256) begin pa[na] = {a_last, a_data}; na++; end
    if (b_valid && out_ready && nb < 256) begin pb[nb] = {b_last, b_data}; nb++; end
    if (c_valid && out_ready && nc < 256) begin pc[nc] = {c_last, c_data}; nc++; last_pop_c = $time; end
    if (a_fd) fd_a++;
    if (c_fd) begin fd_c++; fd_t_c = $time; end
    if (stab_en && prev_stall) chk("stall_hold", 32'({a_valid, a_last, a_data}), 32'(prev_word));
    prev_stall = a_valid && !out_ready;
    prev_word  = {a_valid, a_last, a_data};
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge Clk);
      #1;
    end
  endtask

  task automatic start_frame(input bit to_c, input logic [15:0] b);
    bias = b;
    if (to_c) fs_c = 1'b1; else fs_ab = 1'b1;
    step();
    fs_ab = 1'b0;
    fs_c  = 1'b0;
  endtask

  task automatic cap(input logic [15:0] v);
    finalsum = v;
    cReady   = 1'b1;
    step();
    cReady   = 1'b0;
    step();
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 100; i++) begin
      if (!a_busy && !c_busy) break;
      step();
    end
    chk("idle_timeout", 32'(a_busy | c_busy), 32'd0);
    step(2);
  endtask

  int base_a, base_b, base_c, fdb_a, fdb_c;

  initial begin
    Rst = 1'b0; fs_ab = 1'b0; fs_c = 1'b0; bias = '0;
    cReady = 1'b0; finalsum = '0; out_ready = 1'b1;
    step(3);
    chk("rst_valid", 32'(a_valid), 32'd0);
    chk("rst_busy", 32'(a_busy), 32'd0);
    chk("rst_ovf", 32'(a_ovf), 32'd0);
    chk("rst_fd", 32'(a_fd), 32'd0);
    chk("rst_data", 32'({a_last, a_data}), 32'd0);
    Rst = 1'b1;
    step(2);

    // Test 1: bias 5, ReLU, free-flowing output
    base_a = na; fdb_a = fd_a;
    start_frame(1'b0, 16'd5);
    chk("t1_busy", 32'(a_busy), 32'd1);
    cap(16'd10); cap(16'd20); cap(16'hFFFD); cap(16'd7);
    wait_idle();
    chk("t1_count", 32'(na - base_a), 32'd4);
    chk("t1_d0", 32'(pa[base_a]),     32'h0000F);
    chk("t1_d1", 32'(pa[base_a + 1]), 32'h00019);
    chk("t1_d2", 32'(pa[base_a + 2]), 32'h00002);
    chk("t1_d3", 32'(pa[base_a + 3]), 32'h1000C);
    chk("t1_fd", 32'(fd_a - fdb_a), 32'd1);

    // Test 2: saturation and ReLU corner cases
    base_a = na; base_b = nb;
    start_frame(1'b0, 16'h7FF0);
    cap(16'h0100); cap(16'h0000); cap(16'h0000); cap(16'h0000);
    wait_idle();
    chk("t2_pos_sat", 32'(pb[base_b]), 32'h07FFF);
    chk("t2_bias_only", 32'(pb[base_b + 1]), 32'h07FF0);
    base_a = na; base_b = nb;
    start_frame(1'b0, 16'h8000);
    cap(16'hFFFF); cap(16'h0000); cap(16'h0000); cap(16'h0000);
    wait_idle();
    chk("t2_neg_sat", 32'(pb[base_b]), 32'h08000);
    chk("t2_neg_relu", 32'(pa[base_a]), 32'h00000);
    base_a = na; base_b = nb;
    start_frame(1'b0, 16'h0000);
    cap(16'hFF00); cap(16'h0001); cap(16'h0002); cap(16'h0003);
    wait_idle();
    chk("t2_relu", 32'(pa[base_a]), 32'h00000);
    chk("t2_norelu", 32'(pb[base_b]), 32'h0FF00);
    chk("t2_last", 32'(pb[base_b + 3]), 32'h10003);

    // Test 3: 3x2 frame into a stalled depth-4 FIFO drops the last two
    base_c = nc; fdb_c = fd_c;
    out_ready = 1'b0;
    start_frame(1'b1, 16'h0000);
    for (int i = 1; i <= 6; i++) cap(16'(i));
    step(6);
    chk("t3_ovf", 32'(c_ovf), 32'd1);
    chk("t3_no_pop", 32'(nc - base_c), 32'd0);
    chk("t3_head", 32'({c_valid, c_last, c_data}), 32'h20001);
    out_ready = 1'b1;
    wait_idle();
    chk("t3_count", 32'(nc - base_c), 32'd4);
    for (int i = 0; i < 4; i++) chk("t3_data", 32'(pc[base_c + i]), 32'(i + 1));
    chk("t3_fd", 32'(fd_c - fdb_c), 32'd1);
    chk("t3_fd_after_pop", 32'(fd_t_c > last_pop_c), 32'd1);
    chk("t3_ovf_sticky", 32'(c_ovf), 32'd1);

    // Test 6: reset mid-frame discards everything, next frame restarts at row 0 col 0
    fdb_a = fd_a;
    out_ready = 1'b0;
    start_frame(1'b0, 16'h0000);
    cap(16'd1); cap(16'd2);
    step(4);
    chk("t6_pre_valid", 32'(a_valid), 32'd1);
    Rst = 1'b0;
    step();
    chk("t6_valid", 32'(a_valid), 32'd0);
    chk("t6_busy", 32'(a_busy), 32'd0);
    chk("t6_ovf_c", 32'(c_ovf), 32'd0);
    Rst = 1'b1;
    out_ready = 1'b1;
    step(2);
    base_a = na;
    start_frame(1'b0, 16'h0000);
    cap(16'd10); cap(16'd20); cap(16'd30); cap(16'd40);
    wait_idle();
    chk("t6_count", 32'(na - base_a), 32'd4);
    chk("t6_d2", 32'(pa[base_a + 2]), 32'h0001E);
    chk("t6_d3", 32'(pa[base_a + 3]), 32'h10028);
    chk("t6_fd", 32'(fd_a - fdb_a), 32'd1);

    // Test 4: held level yields one capture; high through reset release yields none
    base_a = na;
    start_frame(1'b0, 16'h0000);
    finalsum = 16'd50; cReady = 1'b1;
    step(5);
    cReady = 1'b0;
    step(8);
    chk("t4_held_count", 32'(na - base_a), 32'd1);
    chk("t4_held_data", 32'(pa[base_a]), 32'h00032);
    cReady = 1'b1;
    Rst = 1'b0;
    step(2);
    Rst = 1'b1;
    step();
    base_a = na;
    start_frame(1'b0, 16'h0000);
    step(10);
    chk("t4_no_cap", 32'(na - base_a), 32'd0);
    cReady = 1'b0;
    step();
    cap(16'd77);
    step(8);
    chk("t4_edge_count", 32'(na - base_a), 32'd1);
    chk("t4_edge_data", 32'(pa[base_a]), 32'h0004D);
    Rst = 1'b0;
    step();
    Rst = 1'b1;
    step(2);

    // Test 5: three-edge latency, then toggling ready against a full FIFO
    base_a = na;
    out_ready = 1'b0;
    start_frame(1'b0, 16'd100);
    finalsum = 16'd1; cReady = 1'b1;
    step();
    cReady = 1'b0;
    chk("t5_lat_k", 32'(a_valid), 32'd0);
    step();
    chk("t5_lat_k1", 32'(a_valid), 32'd0);
    step();
    chk("t5_lat_k2", 32'(a_valid), 32'd0);
    step();
    chk("t5_lat_k3", 32'({a_valid, a_last, a_data}), 32'h20065);
    cap(16'd2); cap(16'd3); cap(16'd4);
    step(6);
    stab_en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      out_ready = ~out_ready;
      step();
    end
    stab_en = 1'b0;
    out_ready = 1'b1;
    wait_idle();
    chk("t5_count", 32'(na - base_a), 32'd4);
    chk("t5_d0", 32'(pa[base_a]),     32'h00065);
    chk("t5_d1", 32'(pa[base_a + 1]), 32'h00066);
    chk("t5_d2", 32'(pa[base_a + 2]), 32'h00067);
    chk("t5_d3", 32'(pa[base_a + 3]), 32'h10068);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
